// File: rtl/mux.sv
// ---------------------------------------------------------------------------
// mux -- two-input data multiplexer with registered copies of the selected
// data and the select line, plus an optional select-toggle counter.
//
// Parameters
//   WIDTH  data width of in0, in1, mux_out and mux_out_q (default 32)
//   CNT_W  width of the select-toggle counter (default 16)
//
// Ports
//   clk             in   1      single clock, all state updates on rising edge
//   rst             in   1      synchronous, active-high reset
//   sel             in   1      1 selects in0, 0 selects in1
//   in0             in   WIDTH  data chosen when sel = 1
//   in1             in   WIDTH  data chosen when sel = 0
//   mux_out         out  WIDTH  combinational selected data (ignores clk/rst)
//   mux_out_q       out  WIDTH  mux_out registered once (one-cycle latency)
//   sel_q           out  1      sel registered once
//   sel_toggle_cnt  out  CNT_W  number of edges on which sel differed from
//                               sel_q; wraps at all-ones. Present only when
//                               the MUX_SEL_CNT_EN macro is defined.
//
// Build option
//   MUX_SEL_CNT_EN  when defined, compiles in the toggle counter and the
//                   sel_toggle_cnt port. When undefined there is no counter
//                   logic and no port; everything else behaves the same.
// ---------------------------------------------------------------------------
module mux #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] mux_out_q,
    output logic             sel_q
`ifdef MUX_SEL_CNT_EN
    ,
    output logic [CNT_W-1:0] sel_toggle_cnt
`endif
);

    // Elaboration-time sanity check on the parameters; costs no hardware.
    if (WIDTH < 1) begin : g_bad_width
        $error("mux: WIDTH must be at least 1");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("mux: CNT_W must be at least 1");
    end

    // -----------------------------------------------------------------------
    // Combinational select. A case statement (rather than ?:) is used so an
    // unknown sel drives the whole bus to X instead of merging in0/in1 bits
    // that happen to agree; synthesis treats the default as don't-care.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: assign a default before the case so no path leaves mux_out
        // unassigned, which would otherwise infer a latch.
        mux_out = 'x;
        case (sel)
            1'b1:    mux_out = in0;
            1'b0:    mux_out = in1;
            default: mux_out = 'x;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / select registers. Reset wins over the load, even when sel is
    // changing on the same edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (rst) begin
            mux_out_q <= '0;
            sel_q     <= 1'b0;
        end else begin
            mux_out_q <= mux_out;
            sel_q     <= sel;
        end
    end

`ifdef MUX_SEL_CNT_EN
    // -----------------------------------------------------------------------
    // Toggle counter: counts edges where the incoming sel differs from the
    // registered one. Because sel_q resets to 0, the first edge after reset
    // counts only if sel is already 1. Wraps silently from all-ones to 0.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_toggle_cnt <= '0;
        end else if (sel != sel_q) begin
            sel_toggle_cnt <= sel_toggle_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mux.sv
// ---------------------------------------------------------------------------
// tb_mux -- directed self-checking bench for mux (default parameters).
// Counter checks are compiled only when MUX_SEL_CNT_EN is defined, matching
// the design build.
// ---------------------------------------------------------------------------
module tb_mux;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             sel;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] mux_out_q;
    logic             sel_q;
`ifdef MUX_SEL_CNT_EN
    logic [CNT_W-1:0] sel_toggle_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mux #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .in0       (in0),
        .in1       (in1),
        .mux_out   (mux_out),
        .mux_out_q (mux_out_q),
        .sel_q     (sel_q)
`ifdef MUX_SEL_CNT_EN
        ,
        .sel_toggle_cnt(sel_toggle_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] observed,
                         input logic [WIDTH-1:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Advance through one rising edge, then sample 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with in0 all-ones selected: mux_out must follow in0 throughout.
        rst = 1'b1;
        sel = 1'b1;
        in0 = 32'hFFFF_FFFF;
        in1 = 32'h0000_0000;
        #1;
        check("rst_mux_out_before_edge", mux_out, 32'hFFFF_FFFF);
        tick();
        check("rst_mux_out_q", mux_out_q, 32'h0);
        check("rst_sel_q", {31'b0, sel_q}, 32'h0);
        check("rst_mux_out_during", mux_out, 32'hFFFF_FFFF);
        tick();
        check("rst_hold_mux_out_q", mux_out_q, 32'h0);
        check("rst_hold_mux_out", mux_out, 32'hFFFF_FFFF);

        // Combinational path, still in reset, zero latency.
        in0 = 32'h15; in1 = 32'h00; sel = 1'b1; #1;
        check("comb_sel1_0x15", mux_out, 32'h15);
        in0 = 32'h0A; #1;
        check("comb_sel1_0x0A", mux_out, 32'h0A);
        sel = 1'b0; in0 = 32'h00; in1 = 32'h15; #1;
        check("comb_sel0_0x15", mux_out, 32'h15);
        in1 = 32'h0A; #1;
        check("comb_sel0_0x0A", mux_out, 32'h0A);
        in0 = 32'h8000_0000; in1 = 32'h0000_0001; sel = 1'b1; #1;
        check("comb_msb_in0", mux_out, 32'h8000_0000);
        sel = 1'b0; #1;
        check("comb_lsb_in1", mux_out, 32'h0000_0001);

        // sel changes on a reset edge: registers still forced to 0.
        sel = 1'b1;
        tick();
        check("rst_sel_change_sel_q", {31'b0, sel_q}, 32'h0);
        check("rst_sel_change_q", mux_out_q, 32'h0);
`ifdef MUX_SEL_CNT_EN
        check("rst_sel_change_cnt", {16'b0, sel_toggle_cnt}, 32'h0);
`endif

        // Leave reset: sel=0, in1=0x12345678. Not visible before the edge.
        rst = 1'b0;
        sel = 1'b0;
        in1 = 32'h1234_5678;
        #1;
        check("lat_before_edge", mux_out_q, 32'h0);
        tick();
        check("lat_after_edge", mux_out_q, 32'h1234_5678);
        check("lat_sel_q0", {31'b0, sel_q}, 32'h0);
`ifdef MUX_SEL_CNT_EN
        check("first_edge_no_toggle", {16'b0, sel_toggle_cnt}, 32'h0);
`endif

        // mux_out_q holds between edges despite input activity.
        in1 = 32'hDEAD_BEEF; #2;
        sel = 1'b1; in0 = 32'hCAFE_F00D; #1;
        check("hold_between_edges", mux_out_q, 32'h1234_5678);
        check("comb_follow_in0", mux_out, 32'hCAFE_F00D);

        // sel=1 captured with one cycle latency, full-width value.
        tick();
        check("sel_q_one", {31'b0, sel_q}, 32'h1);
        check("q_in0_full", mux_out_q, 32'hCAFE_F00D);
        sel = 1'b0; #1;
        check("sel_q_holds", {31'b0, sel_q}, 32'h1);
        tick();
        check("sel_q_zero", {31'b0, sel_q}, 32'h0);
        check("q_in1_full", mux_out_q, 32'hDEAD_BEEF);

        // Reset again mid-run clears the registers.
        rst = 1'b1;
        tick();
        check("rerst_q", mux_out_q, 32'h0);
        check("rerst_sel_q", {31'b0, sel_q}, 32'h0);
        rst = 1'b0;

`ifdef MUX_SEL_CNT_EN
        // Five toggles after reset -> count 5.
        for (int i = 0; i < 5; i++) begin
            sel = ~sel_q;
            tick();
        end
        check("cnt_five", {16'b0, sel_toggle_cnt}, 32'd5);
        // Steady sel: no counting.
        sel = sel_q;
        tick();
        tick();
        check("cnt_steady", {16'b0, sel_toggle_cnt}, 32'd5);
        // Toggle up to all-ones (bounded), then once more to wrap.
        for (int i = 0; i < 70000 && sel_toggle_cnt != 16'hFFFF; i++) begin
            sel = ~sel_q;
            tick();
        end
        check("cnt_all_ones", {16'b0, sel_toggle_cnt}, 32'h0000_FFFF);
        sel = ~sel_q;
        tick();
        check("cnt_wrap", {16'b0, sel_toggle_cnt}, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux.md
MUX -- requirements
Module: mux

Interface
REQ-001 Parameter WIDTH, default 32: data width of in0, in1, mux_out and mux_out_q.
REQ-002 Parameter CNT_W, default 16: width of the select-toggle counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sel  input  1  select; 1 selects in0, 0 selects in1.
REQ-006 in0  input  WIDTH  data input chosen when sel=1.
REQ-007 in1  input  WIDTH  data input chosen when sel=0.
REQ-008 mux_out  output  WIDTH  combinational selected data.
REQ-009 mux_out_q  output  WIDTH  registered copy of mux_out.
REQ-010 sel_q  output  1  registered copy of sel.
REQ-011 sel_toggle_cnt  output  CNT_W  count of sel changes; present only with MUX_SEL_CNT_EN.

Function
REQ-012 mux_out SHALL equal in0 when sel=1 and in1 when sel=0, with zero clock latency.
REQ-013 mux_out SHALL be purely combinational, independent of clk and rst, and SHALL settle within the same delta as any input change.
REQ-014 If sel is X or Z, mux_out SHALL be driven all-X.
REQ-015 On each rising clk edge with rst=0, mux_out_q SHALL load mux_out and sel_q SHALL load sel, giving one cycle of latency.
REQ-016 mux_out_q SHALL hold its value between edges, regardless of input activity.
REQ-017 The toggle counter SHALL increment by 1 on any rising edge where sel differs from sel_q and rst=0.
REQ-018 The toggle counter SHALL wrap from all-ones to 0 with no saturation or flag.
REQ-019 Bit widths SHALL be preserved exactly, with no sign extension or truncation on any data path.

Reset
REQ-020 On a rising edge with rst=1, mux_out_q SHALL become 0, sel_q SHALL become 0 and sel_toggle_cnt SHALL become 0.
REQ-021 rst SHALL take priority over all other register updates, including during a sel change.
REQ-022 rst SHALL NOT affect mux_out, which keeps following REQ-012 during reset.
REQ-023 On the first edge after rst deasserts, no toggle SHALL be counted unless sel differs from the reset value 0 of sel_q.

Configuration
REQ-024 Macro MUX_SEL_CNT_EN SHALL, when defined, compile in the toggle counter and the sel_toggle_cnt port.
REQ-025 When MUX_SEL_CNT_EN is undefined, no counter logic SHALL exist and the sel_toggle_cnt port SHALL be absent.
REQ-026 All other behaviour SHALL be identical with and without MUX_SEL_CNT_EN.

Verification
REQ-027 sel=1, in0=0x15, in1=0x00, wait 1 time unit -> mux_out=0x15.
REQ-028 sel=1, in0=0x0A, in1=0x00 -> mux_out=0x0A; then sel=0, in0=0x00, in1=0x15 -> mux_out=0x15; then in1=0x0A -> mux_out=0x0A.
REQ-029 rst=1 for 1 edge with in0=0xFFFFFFFF and sel=1 -> mux_out_q=0, sel_q=0 and mux_out=0xFFFFFFFF throughout.
REQ-030 rst=0, sel=0, in1=0x12345678, clock 1 edge -> mux_out_q=0x12345678 after that edge, not before it.
REQ-031 With MUX_SEL_CNT_EN, toggle sel every cycle for 5 edges after reset -> sel_toggle_cnt=5; forcing the count to 0xFFFF and toggling once more -> 0x0000.
REQ-032 sel changes on the same edge that rst=1 -> counter stays 0 and sel_q=0.
